laplace_kernel_acc: RTL and testbench



---
 rtl/laplace_pkg.sv | 20 ++
 rtl/lsb_or_adder_param.sv | 38 +++
 rtl/laplace_kernel_acc.sv | 160 ++++++++++++++++
 tb/tb_laplace_kernel_acc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/laplace_pkg.sv
// ---------------------------------------------------------------------------
// laplace_pkg
// Shared definitions for the Laplacian kernel engine: FSM state encoding and
// the datapath width constants. No ports (package).
// ---------------------------------------------------------------------------
package laplace_pkg;

   localparam int PIX_W     = 8;      // pixel width
   localparam int ACC_W     = 10;     // neighbour accumulator width (PIX_W+2)
   localparam int NEIGH_CNT = 4;      // neighbours per kernel (N, E, S, W)
   localparam int PIX_MAX   = 255;    // largest clamped output value

   typedef enum logic [1:0] {
      S_CENTER = 2'd0,
      S_NEIGH  = 2'd1,
      S_CALC   = 2'd2,
      S_OUT    = 2'd3
   } state_t;

endpackage : laplace_pkg

// File: rtl/lsb_or_adder_param.sv
// ---------------------------------------------------------------------------
// lsb_or_adder_param
// Combinational approximate adder. The low APPROX_BITS bits are the OR of the
// operands; the upper field is an exact add with carry-in 0. The final carry
// is dropped. APPROX_BITS = 0 degenerates to an exact WIDTH-bit add.
// Ports:
//   a, b  in  WIDTH  operands
//   sum   out WIDTH  approximate sum
// ---------------------------------------------------------------------------
module lsb_or_adder_param #(
   parameter int WIDTH       = 10,
   parameter int APPROX_BITS = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   generate
      if (APPROX_BITS <= 0) begin : g_exact
         // Exact add, carry out discarded.
         assign sum = a + b;
      end else if (APPROX_BITS >= WIDTH) begin : g_all_or
         // Whole word approximated: pure bitwise OR.
         assign sum = a | b;
      end else begin : g_split
         localparam int UP_W = WIDTH - APPROX_BITS;
         logic [UP_W-1:0]        upper_s;
         logic [APPROX_BITS-1:0] lower_s;

         // No carry crosses from the OR field into the exact field.
         assign upper_s = a[WIDTH-1:APPROX_BITS] + b[WIDTH-1:APPROX_BITS];
         assign lower_s = a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0];
         assign sum     = {upper_s, lower_s};
      end
   endgenerate

endmodule : lsb_or_adder_param

// File: rtl/laplace_kernel_acc.sv
// ---------------------------------------------------------------------------
// laplace_kernel_acc
// Sequential 4-neighbour Laplacian: takes a pixel stream C, N, E, S, W,
// accumulates N+E+S+W through the approximate adder and produces
// 4*C - sum, both raw (signed) and clamped to the pixel range. Input and
// output never overlap: a pending result blocks new pixels.
// Ports:
//   Clk        in   1        clock, rising edge
//   Rst        in   1        asynchronous active-high reset
//   In_Valid   in   1        input pixel valid
//   In_Ready   out  1        block can accept a pixel
//   In_Data    in   PIX_W    unsigned pixel
//   Out_Valid  out  1        result valid
//   Out_Ready  in   1        downstream accepts result
//   Out_Pix    out  PIX_W    result clamped to [0, 2^PIX_W-1]
//   Out_Raw    out  ACC_W+1  signed two's-complement result
// ---------------------------------------------------------------------------
module laplace_kernel_acc #(
   parameter int PIX_W       = laplace_pkg::PIX_W,
   parameter int APPROX_BITS = 3,
   parameter int ACC_W       = laplace_pkg::ACC_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [PIX_W-1:0] In_Data,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [PIX_W-1:0] Out_Pix,
   output logic [ACC_W:0]   Out_Raw
);

   import laplace_pkg::*;

   localparam int RAW_W = ACC_W + 1;

   state_t             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [PIX_W-1:0]   center_q, center_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               out_valid_q, out_valid_d;
   logic [PIX_W-1:0]   out_pix_q, out_pix_d;
   logic [RAW_W-1:0]   out_raw_q, out_raw_d;

   logic               in_fire_s;
   logic [ACC_W-1:0]   add_sum_s;
   logic [RAW_W-1:0]   center_x4_s;
   logic [RAW_W-1:0]   diff_s;
   logic [PIX_W-1:0]   clamp_s;

   assign In_Ready  = (state_q == S_CENTER) || (state_q == S_NEIGH);
   assign in_fire_s = In_Valid && In_Ready;

   assign Out_Valid = out_valid_q;
   assign Out_Pix   = out_pix_q;
   assign Out_Raw   = out_raw_q;

   lsb_or_adder_param #(
      .WIDTH       (ACC_W),
      .APPROX_BITS (APPROX_BITS)
   ) u_adder (
      .a   (acc_q),
      .b   (ACC_W'(In_Data)),
      .sum (add_sum_s)
   );

   // Signed result 4*C - acc, computed one bit wider than the accumulator.
   assign center_x4_s = RAW_W'({center_q, 2'b00});
   assign diff_s      = center_x4_s - {1'b0, acc_q};

   // Saturate to the pixel range: negative -> 0, above max -> all ones.
   always_comb begin
      clamp_s = diff_s[PIX_W-1:0];
      if (diff_s[RAW_W-1]) begin
         clamp_s = '0;
      end else if (|diff_s[ACC_W-1:PIX_W]) begin
         clamp_s = '1;
      end else begin
         clamp_s = diff_s[PIX_W-1:0];
      end
   end

   // Next-state and datapath update for the kernel sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      center_d    = center_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_pix_d   = out_pix_q;
      out_raw_d   = out_raw_q;

      case (state_q)
         S_CENTER: begin
            if (in_fire_s) begin
               center_d = In_Data;
               acc_d    = '0;
               cnt_d    = 2'd0;
               state_d  = S_NEIGH;
            end else begin
               state_d  = S_CENTER;
            end
         end
         S_NEIGH: begin
            if (in_fire_s) begin
               acc_d = add_sum_s;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'(NEIGH_CNT - 1)) begin
                  state_d = S_CALC;
               end else begin
                  state_d = S_NEIGH;
               end
            end else begin
               state_d = S_NEIGH;
            end
         end
         S_CALC: begin
            out_raw_d   = diff_s;
            out_pix_d   = clamp_s;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_valid_q && Out_Ready) begin
               out_valid_d = 1'b0;
               state_d     = S_CENTER;
            end else begin
               state_d     = S_OUT;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_CENTER;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial kernel.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= S_CENTER;
         cnt_q       <= 2'd0;
         center_q    <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_raw_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         center_q    <= center_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_pix_q   <= out_pix_d;
         out_raw_q   <= out_raw_d;
      end
   end

endmodule : laplace_kernel_acc

// File: tb/tb_laplace_kernel_acc.sv
// ---------------------------------------------------------------------------
// tb_laplace_kernel_acc
// Drives one approximate (APPROX_BITS=3) and one exact (APPROX_BITS=0)
// instance with identical stimulus. Expected results are hand-computed and
// queued per instance; a monitor per instance pops on each accepted result.
// ---------------------------------------------------------------------------
module tb_laplace_kernel_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        out_ready = 1'b1;

   logic        a_in_ready, a_out_valid;
   logic [7:0]  a_out_pix;
   logic [10:0] a_out_raw;
   logic        e_in_ready, e_out_valid;
   logic [7:0]  e_out_pix;
   logic [10:0] e_out_raw;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int raw;
      int pix;
   } exp_t;

   exp_t q_apx[$];
   exp_t q_exa[$];

   always #5 clk = ~clk;

   laplace_kernel_acc #(.PIX_W(8), .APPROX_BITS(3), .ACC_W(10)) dut_apx (
      .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(a_in_ready),
      .In_Data(in_data), .Out_Valid(a_out_valid), .Out_Ready(out_ready),
      .Out_Pix(a_out_pix), .Out_Raw(a_out_raw)
   );

   laplace_kernel_acc #(.PIX_W(8), .APPROX_BITS(0), .ACC_W(10)) dut_exa (
      .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(e_in_ready),
      .In_Data(in_data), .Out_Valid(e_out_valid), .Out_Ready(out_ready),
      .Out_Pix(e_out_pix), .Out_Raw(e_out_raw)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Approximate-instance monitor: compare on every accepted result.
   always @(negedge clk) begin
      if (!rst && a_out_valid && out_ready) begin
         if (q_apx.size() == 0) begin
            chk("apx_unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = q_apx.pop_front();
            chk("apx_out_raw", $signed(a_out_raw), e.raw);
            chk("apx_out_pix", a_out_pix, e.pix);
         end
      end
   end

   // Exact-instance monitor.
   always @(negedge clk) begin
      if (!rst && e_out_valid && out_ready) begin
         if (q_exa.size() == 0) begin
            chk("exa_unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = q_exa.pop_front();
            chk("exa_out_raw", $signed(e_out_raw), e.raw);
            chk("exa_out_pix", e_out_pix, e.pix);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic push_exp(input int ar, input int ap, input int er, input int ep);
      exp_t a;
      exp_t e;
      a.raw = ar; a.pix = ap;
      e.raw = er; e.pix = ep;
      q_apx.push_back(a);
      q_exa.push_back(e);
   endtask

   // Offer one pixel after 'gap' idle cycles; returns #1 after the transfer edge.
   task automatic send_pix(input logic [7:0] d, input int gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         in_valid = 1'b0;
         in_data  = 8'hA5;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      while (!a_in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_kernel(input logic [7:0] c, input logic [7:0] n,
                              input logic [7:0] e, input logic [7:0] s,
                              input logic [7:0] w, input int gap);
      send_pix(c, gap);
      send_pix(n, gap);
      send_pix(e, gap);
      send_pix(s, gap);
      send_pix(w, gap);
   endtask

   // With Out_Ready high: valid low right after W, high one edge later, one cycle wide.
   task automatic check_latency(input string tag);
      chk({tag, "_valid_after_w"}, a_out_valid, 0);
      @(posedge clk); #1;
      chk({tag, "_valid_2nd_edge"}, a_out_valid, 1);
      chk({tag, "_exa_valid_2nd_edge"}, e_out_valid, 1);
      chk({tag, "_in_ready_pending"}, a_in_ready, 0);
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, a_out_valid, 0);
      chk({tag, "_in_ready_back"}, a_in_ready, 1);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      #1;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_pix", a_out_pix, 0);
      chk("rst_out_raw", a_out_raw, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", a_in_ready, 1);

      // Idle cycles with In_Valid low must not advance anything
      repeat (3) @(posedge clk);
      #1;
      chk("idle_out_valid", a_out_valid, 0);

      out_ready = 1'b1;

      // Back-to-back C=30, 20 x4: approx acc 68 -> 52, exact 80 -> 40
      push_exp(52, 52, 40, 40);
      send_kernel(8'd30, 8'd20, 8'd20, 8'd20, 8'd20, 0);
      check_latency("b2b");

      // Same kernel with an idle cycle before each pixel
      push_exp(52, 52, 40, 40);
      send_kernel(8'd30, 8'd20, 8'd20, 8'd20, 8'd20, 1);
      check_latency("gaps");

      // C=0, neighbours 255: approx acc 999 -> -999; exact -1020; both clamp to 0
      push_exp(-999, 0, -1020, 0);
      send_kernel(8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 0);
      check_latency("neg");
      chk("neg_raw_bits", a_out_raw, 11'h419);

      // C=255, neighbours 0: 1020, clamps to 255
      push_exp(1020, 255, 1020, 255);
      send_kernel(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 0);
      check_latency("pos");

      // C=50, N..W=10,20,30,40: approx acc 10,30,54,94 -> 106; exact 100
      push_exp(106, 106, 100, 100);
      send_kernel(8'd50, 8'd10, 8'd20, 8'd30, 8'd40, 2);
      check_latency("mixed");

      // Backpressure: result pending for 3 cycles with input offered
      out_ready = 1'b0;
      push_exp(52, 52, 40, 40);
      send_kernel(8'd30, 8'd20, 8'd20, 8'd20, 8'd20, 0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'd30;
      for (int i = 0; i < 3; i++) begin
         chk("bp_out_valid", a_out_valid, 1);
         chk("bp_in_ready", a_in_ready, 0);
         chk("bp_out_raw_stable", $signed(a_out_raw), 52);
         chk("bp_out_pix_stable", a_out_pix, 52);
         @(posedge clk); #1;
      end
      chk("bp_exa_raw_stable", $signed(e_out_raw), 40);
      // Next kernel's center is already on the bus; it must be taken right after acceptance
      push_exp(52, 52, 40, 40);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_accept_valid", a_out_valid, 0);
      chk("bp_accept_in_ready", a_in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      send_pix(8'd20, 0);
      send_pix(8'd20, 0);
      send_pix(8'd20, 0);
      send_pix(8'd20, 0);
      check_latency("bp_next");
      chk("pre_rst_out_pix", a_out_pix, 52);

      // Reset after 2 pixels of a kernel (255 center would give 1020 if kept)
      send_pix(8'd255, 0);
      send_pix(8'd1, 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", a_out_valid, 0);
      chk("mid_rst_in_ready", a_in_ready, 1);
      chk("mid_rst_out_pix", a_out_pix, 0);
      chk("mid_rst_out_raw", a_out_raw, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      push_exp(52, 52, 40, 40);
      send_kernel(8'd30, 8'd20, 8'd20, 8'd20, 8'd20, 0);
      check_latency("post_rst");

      repeat (3) @(posedge clk);
      #1;
      chk("apx_queue_empty", q_apx.size(), 0);
      chk("exa_queue_empty", q_exa.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_laplace_kernel_acc
